cfg_chain_piso: RTL and testbench
=================================

# cfg_chain_piso

Parallel-in serial-out driver for the FPGA configuration scan chain. Sits directly downstream of the serial-in parallel-out deserializer and the decryption path. Accepts DATA_WIDTH-bit configuration words over a valid/ready handshake and shifts them LSB-first into a chain of CHAIN_LENGTH bits. When the frame is complete it pulses the chain latch and signals completion.

## Interface
- DATA_WIDTH, 128: width of one configuration word.
- CHAIN_LENGTH, 1024: total bits in the configuration chain. Need not be a multiple of DATA_WIDTH.
- LATCH_CYCLES, 2: number of cycles latch_o is held high after the last bit (≥1).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a frame from IDLE.
- abort  in  1  terminates the frame; has priority over all other inputs.
- data_i  in  DATA_WIDTH  configuration word; bit 0 is shifted first.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  block accepts data_i this cycle.
- scan_o  out  1  serial data to chain head.
- scan_en_o  out  1  chain shifts on the posedge where this is high.
- latch_o  out  1  chain latch/program strobe.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse on frame completion.

## Operation
- States:
  - IDLE → SHIFT on start.
  - SHIFT → LATCH after bit CHAIN_LENGTH-1 is shifted.
  - LATCH → DONE after LATCH_CYCLES cycles.
  - DONE → IDLE after 1 cycle.
  - Any state → IDLE on abort.
- Two word slots:
  - hold register (hold_valid).
  - shift register (sh_valid, sh_cnt = bits remaining in the current word).
- Accept: valid_i && ready_o.
  - ready_o = (state==SHIFT) && !hold_valid && (words_accepted < ceil(CHAIN_LENGTH/DATA_WIDTH)).
  - ready_o is a function of registered state only; it does not depend on valid_i.
- Transfer:
  - hold loads the shift register on the edge where the shift register is empty, or is consuming its last bit.
  - Same-edge accept into hold and transfer out of hold is legal.
- Shift outputs:
  - scan_o = shreg[0], scan_en_o = sh_valid.
  - Each edge with sh_valid shifts shreg right by one, decrements sh_cnt, and increments bit_cnt.
- Final partial word: only CHAIN_LENGTH mod DATA_WIDTH bits are shifted (the low bits); the upper bits are discarded.
- Underrun (both slots empty in SHIFT): scan_en_o low, bit_cnt held, no error; shifting resumes when data arrives.
- In IDLE, LATCH and DONE: ready_o=0, and valid_i is ignored.
- start while busy: ignored.
- start and abort in the same cycle: abort wins, state stays IDLE.
- Abort:
  - next state IDLE; hold, shreg and counters cleared.
  - latch_o and done_o are not asserted.
  - the chain contents are undefined.

## Timing
- Reset values:
  - all outputs 0: ready_o, scan_o, scan_en_o, latch_o, busy_o, done_o.
  - state IDLE; all counters and registers 0.
- start at edge E0:
  - busy_o and ready_o are high after E0.
- Word accepted at edge A:
  - hold_valid after A.
  - shift register loaded at A+1; scan_o = bit 0 and scan_en_o=1 after A+1.
- With valid_i continuously high, the stream is gapless:
  - consecutive words shift back-to-back with no idle cycle.
  - first accept to last scan_en_o cycle = CHAIN_LENGTH+1 cycles.
- Latch and done:
  - latch_o rises the cycle after the last scan_en_o cycle and stays high for exactly LATCH_CYCLES cycles.
  - done_o pulses the following cycle, while busy_o is still high.
  - busy_o falls one cycle later.
- Counter widths:
  - bit_cnt uses $clog2(CHAIN_LENGTH+1) bits.
  - sh_cnt uses $clog2(DATA_WIDTH+1) bits.
  - No wrap: the SHIFT→LATCH transition fires at bit_cnt==CHAIN_LENGTH-1 with sh_valid.
- Reset asserted mid-frame: immediate return to reset values, no latch_o glitch.

## Structure
- Shared package cfg_pkg holds:
  - the state enum (IDLE, SHIFT, LATCH, DONE).
  - the default LATCH_CYCLES.
  - the words-per-frame function ceil(CHAIN_LENGTH/DATA_WIDTH).
- One sub-module, cfg_word_buf, holds the two word slots: hold register plus shift register, their valid flags, and sh_cnt. It exposes the load/shift/consume strobes.
- The top level holds the FSM, bit_cnt, words_accepted and the latch counter.

## Test plan
All scenarios use DATA_WIDTH=8, CHAIN_LENGTH=20, LATCH_CYCLES=2.
- Reset then idle:
  - all outputs 0.
  - valid_i=1 with data_i=8'hFF gives ready_o=0 and no scan_en_o.
- Full frame: start, then words 8'hA5, 8'h3C, 8'h0F with valid_i held high:
  - scan_o sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1 over 20 consecutive scan_en_o cycles.
  - latch_o high 2 cycles, then done_o for 1 cycle.
- Underrun: second word delayed 5 cycles:
  - scan_en_o low exactly 5 cycles mid-frame.
  - the bit sequence is otherwise identical to the full-frame case.
- Extra words: a 4th valid_i after 3 accepts:
  - ready_o stays 0; no extra scan_en_o cycles.
- Abort after 10 bits:
  - state returns to IDLE next cycle; latch_o and done_o never asserted.
  - a new start then gives a clean 20-bit frame.
- Start with abort in the same cycle, plus reset mid-shift:
  - both leave all outputs 0.
  - the following frame completes correctly.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and helpers for the configuration-chain serializer.
// Holds the FSM state encoding, the latch-width default and frame sizing.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DONE
  } cfg_state_e;

  localparam int DEF_LATCH_CYCLES = 2;

  function automatic int words_per_frame(input int chain_len, input int data_w);
    return (chain_len + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/cfg_chain_piso_if.sv
// Word handshake between the decryption path and the chain serializer.
interface cfg_chain_piso_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;

  modport master (output data_i, valid_i, input ready_o);
  modport slave  (input data_i, valid_i, output ready_o);
endinterface

// File: rtl/cfg_word_buf.sv
// Two-slot word buffer: a hold register feeding an LSB-first shift register.
// Each word carries its own bit count so a short final word stops early.
module cfg_word_buf #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [CNT_W-1:0]      push_len,
  output logic                  hold_valid,
  output logic                  shift,
  output logic                  scan_bit
);

  logic [DATA_WIDTH-1:0] hold_reg, shreg;
  logic [CNT_W-1:0]      hold_len, sh_cnt;
  logic                  sh_valid, load, consume;

  assign shift    = sh_valid;
  assign consume  = sh_valid && (sh_cnt == CNT_W'(1));
  assign load     = hold_valid && (!sh_valid || consume);
  assign scan_bit = shreg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg   <= '0;
      hold_len   <= '0;
      hold_valid <= 1'b0;
      shreg      <= '0;
      sh_cnt     <= '0;
      sh_valid   <= 1'b0;
    end else if (clr) begin
      hold_reg   <= '0;
      hold_len   <= '0;
      hold_valid <= 1'b0;
      shreg      <= '0;
      sh_cnt     <= '0;
      sh_valid   <= 1'b0;
    end else begin
      if (load) hold_valid <= 1'b0;
      if (push) begin
        hold_valid <= 1'b1;
        hold_reg   <= push_data;
        hold_len   <= push_len;
      end
      // Clearing on the last bit keeps discarded upper bits of a short word off scan_bit.
      if (load) begin
        shreg    <= hold_reg;
        sh_cnt   <= hold_len;
        sh_valid <= 1'b1;
      end else if (shift) begin
        shreg    <= consume ? '0 : (shreg >> 1);
        sh_cnt   <= sh_cnt - 1'b1;
        sh_valid <= !consume;
      end
    end
  end

endmodule

// File: rtl/cfg_chain_piso.sv
// Configuration scan-chain driver: streams words LSB-first into the chain,
// then strobes the chain latch and reports completion.
module cfg_chain_piso
  import cfg_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int CHAIN_LENGTH = 1024,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  cfg_chain_piso_if.slave  bus,
  output logic             scan_o,
  output logic             scan_en_o,
  output logic             latch_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int WORDS = words_per_frame(CHAIN_LENGTH, DATA_WIDTH);
  localparam int BW    = $clog2(CHAIN_LENGTH + 1);
  localparam int CW    = $clog2(DATA_WIDTH + 1);
  localparam int WW    = $clog2(WORDS + 1);
  localparam int LW    = $clog2(LATCH_CYCLES + 1);
  localparam int REM   = CHAIN_LENGTH % DATA_WIDTH;

  localparam logic [CW-1:0] FULL_LEN  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_LEN  = CW'((REM == 0) ? DATA_WIDTH : REM);
  localparam logic [BW-1:0] LAST_BIT  = BW'(CHAIN_LENGTH - 1);
  localparam logic [WW-1:0] WORDS_W   = WW'(WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(LATCH_CYCLES - 1);

  cfg_state_e      state, state_nxt;
  logic [BW-1:0]   bit_cnt;
  logic [WW-1:0]   words_acc;
  logic [LW-1:0]   lat_cnt;
  logic            hold_valid, shift, accept;
  logic [CW-1:0]   push_len;

  assign bus.ready_o = (state == SHIFT) && !hold_valid && (words_acc < WORDS_W);
  assign accept      = bus.valid_i && bus.ready_o;
  assign push_len    = (words_acc == LAST_WORD) ? LAST_LEN : FULL_LEN;

  cfg_word_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (abort),
    .push       (accept),
    .push_data  (bus.data_i),
    .push_len   (push_len),
    .hold_valid (hold_valid),
    .shift      (shift),
    .scan_bit   (scan_o)
  );

  assign scan_en_o = shift;
  assign latch_o   = (state == LATCH);
  assign done_o    = (state == DONE);
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (shift && (bit_cnt == LAST_BIT)) state_nxt = LATCH;
      LATCH:   if (lat_cnt == LAT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Frame counters only run in SHIFT; any other state (or abort) parks them at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      words_acc <= '0;
    end else if (abort || (state != SHIFT)) begin
      bit_cnt   <= '0;
      words_acc <= '0;
    end else begin
      if (shift)  bit_cnt   <= bit_cnt + 1'b1;
      if (accept) words_acc <= words_acc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  lat_cnt <= '0;
    else if (state == LATCH)  lat_cnt <= lat_cnt + 1'b1;
    else                      lat_cnt <= '0;
  end

endmodule

// File: tb/tb_cfg_chain_piso.sv
// Bench for cfg_chain_piso with DATA_WIDTH=8, CHAIN_LENGTH=20, LATCH_CYCLES=2.
module tb_cfg_chain_piso;
  localparam int DW = 8;
  localparam int CL = 20;
  localparam int LC = 2;
  localparam int NW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic scan_o, scan_en_o, latch_o, busy_o, done_o;

  cfg_chain_piso_if #(.DATA_WIDTH(DW)) bus ();

  cfg_chain_piso #(.DATA_WIDTH(DW), .CHAIN_LENGTH(CL), .LATCH_CYCLES(LC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .scan_o    (scan_o),
    .scan_en_o (scan_en_o),
    .latch_o   (latch_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model: phase (0 idle, 1 shift, 2 latch, 3 done) plus a bit queue.
  // Each accepted word contributes its bits, visible from the second edge after acceptance.
  int ph = 0, m_words = 0, m_bits = 0, m_lat = 0, cyc = 0;
  bit q_bit[$];
  int q_rel[$];
  int q_wid[$];

  function automatic logic m_en();
    return (q_bit.size() > 0) && (q_rel[0] <= cyc);
  endfunction

  // Ready when shifting, frame not full, and no accepted word is still waiting its turn.
  function automatic logic m_ready();
    int nw = 0;
    int last = -1;
    foreach (q_wid[i]) if (q_wid[i] != last) begin nw++; last = q_wid[i]; end
    if (m_en()) nw--;
    return (ph == 1) && (m_words < NW) && (nw == 0);
  endfunction

  task automatic m_clear();
    q_bit.delete(); q_rel.delete(); q_wid.delete();
    m_words = 0; m_bits = 0; m_lat = 0;
  endtask

  always @(posedge clk) begin
    logic en, rdy;
    logic [DW-1:0] d;
    int n;
    en  = m_en();
    rdy = m_ready();
    d   = bus.data_i;
    if (rst || abort) begin
      ph = 0;
      m_clear();
    end else begin
      case (ph)
        0: if (start) begin ph = 1; m_clear(); end
        1: begin
          if (en) begin
            q_bit.pop_front(); q_rel.pop_front(); q_wid.pop_front();
            m_bits++;
            if (m_bits == CL) begin ph = 2; m_lat = 0; end
          end
          if (bus.valid_i && rdy) begin
            n = (m_words == NW - 1) ? CL - (NW - 1) * DW : DW;
            for (int i = 0; i < n; i++) begin
              q_bit.push_back(d[i]); q_rel.push_back(cyc + 2); q_wid.push_back(m_words);
            end
            m_words++;
          end
        end
        2: begin m_lat++; if (m_lat == LC) ph = 3; end
        default: ph = 0;
      endcase
    end
    cyc++;
  end

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
    end
  endtask

  // Per-cycle compare plus statistics for the literal frame checks.
  bit gbits[$];
  int en_cyc[$];
  int latch_cnt = 0, done_cnt = 0, ncyc = 0;

  always @(negedge clk) begin
    logic en;
    en = m_en();
    chk_bit("busy_o", busy_o, ph != 0);
    chk_bit("latch_o", latch_o, ph == 2);
    chk_bit("done_o", done_o, ph == 3);
    chk_bit("scan_en_o", scan_en_o, en);
    chk_bit("ready_o", bus.ready_o, m_ready());
    if (en) chk_bit("scan_o", scan_o, q_bit[0]);
    if (scan_en_o) begin gbits.push_back(scan_o); en_cyc.push_back(ncyc); end
    latch_cnt += int'(latch_o);
    done_cnt  += int'(done_o);
    ncyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bus.data_i  = d;
    bus.valid_i = 1'b1;
    checks++;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) begin @(posedge clk); #1; return; end
    end
    errors++;
    $display("FAIL send_timeout: ready_o stayed low for word 0x%h", d);
  endtask

  task automatic wait_idle();
    checks++;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (busy_o === 1'b0) begin #1; return; end
    end
    errors++;
    $display("FAIL idle_timeout: busy_o still %b after 200 cycles", busy_o);
  endtask

  // Frame of A5,3C,0F; gap inserts a 5-cycle underrun after the first word.
  task automatic run_frame(input string tag, input bit gap, input bit extra);
    int be, bl, bd, g;
    logic [19:0] v;
    be = gbits.size(); bl = latch_cnt; bd = done_cnt;
    pulse_start();
    send(8'hA5);
    if (gap) begin
      bus.valid_i = 1'b0;
      repeat (12) @(posedge clk);
      #1;
    end
    send(8'h3C);
    send(8'h0F);
    if (extra) bus.data_i = 8'hFF;
    else       bus.valid_i = 1'b0;
    wait_idle();
    bus.valid_i = 1'b0;
    v = '0;
    for (int i = 0; i < 20; i++) if (be + i < gbits.size()) v[i] = gbits[be + i];
    g = (gbits.size() >= be + 20) ? en_cyc[be + 19] - en_cyc[be] + 1 - 20 : -1;
    chk_int({tag, "_bits"}, int'(v), 32'hF3CA5);
    chk_int({tag, "_en_cycles"}, gbits.size() - be, 20);
    chk_int({tag, "_gap"}, g, gap ? 5 : 0);
    chk_int({tag, "_latch_cycles"}, latch_cnt - bl, 2);
    chk_int({tag, "_done_cycles"}, done_cnt - bd, 1);
    tick();
  endtask

  initial begin
    int be, bl, bd;
    bit do_abort;
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then stray data while idle.
    chk_bit("rst_ready_o", bus.ready_o, 1'b0);
    chk_bit("rst_scan_o", scan_o, 1'b0);
    chk_bit("rst_busy_o", busy_o, 1'b0);
    be = gbits.size();
    bus.data_i = 8'hFF; bus.valid_i = 1'b1;
    repeat (5) tick();
    chk_bit("idle_ready_o", bus.ready_o, 1'b0);
    chk_int("idle_en_cycles", gbits.size() - be, 0);
    bus.valid_i = 1'b0;
    tick();

    run_frame("full", 1'b0, 1'b0);
    run_frame("underrun", 1'b1, 1'b0);
    run_frame("extra", 1'b0, 1'b1);

    // Abort after about 10 bits.
    be = gbits.size(); bl = latch_cnt; bd = done_cnt;
    pulse_start();
    bus.data_i = 8'h5A; bus.valid_i = 1'b1;
    for (int t = 0; t < 100 && (gbits.size() - be) < 10; t++) @(negedge clk);
    #1 abort = 1'b1; bus.valid_i = 1'b0;
    tick();
    abort = 1'b0;
    repeat (4) tick();
    chk_bit("abort_busy_o", busy_o, 1'b0);
    chk_int("abort_latch_cycles", latch_cnt - bl, 0);
    chk_int("abort_done_cycles", done_cnt - bd, 0);
    run_frame("post_abort", 1'b0, 1'b0);

    // Start and abort together, then reset mid-shift.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (2) tick();
    chk_bit("startabort_busy_o", busy_o, 1'b0);
    pulse_start();
    bus.data_i = 8'hC3; bus.valid_i = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    #1 rst = 1'b1; bus.valid_i = 1'b0;
    repeat (2) tick();
    chk_bit("midrst_scan_en_o", scan_en_o, 1'b0);
    chk_bit("midrst_latch_o", latch_o, 1'b0);
    chk_bit("midrst_busy_o", busy_o, 1'b0);
    rst = 1'b0;
    tick();
    run_frame("post_reset", 1'b0, 1'b0);

    // Randomized frames: random data, gaps, stray starts and occasional aborts.
    for (int it = 0; it < 30; it++) begin
      do_abort = ($urandom_range(0, 4) == 0);
      pulse_start();
      for (int w = 0; w < NW; w++) begin
        int gp;
        gp = $urandom_range(0, 4);
        if (gp > 0) begin bus.valid_i = 1'b0; repeat (gp) tick(); end
        send(DW'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          bus.valid_i = 1'b0; start = 1'b1; tick(); start = 1'b0;
        end
        if (do_abort && w == 1) begin
          bus.valid_i = 1'b0;
          repeat ($urandom_range(0, 6)) tick();
          abort = 1'b1; tick(); abort = 1'b0;
          break;
        end
      end
      bus.valid_i = ($urandom_range(0, 1) == 1);
      bus.data_i  = DW'($urandom);
      wait_idle();
      bus.valid_i = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
